// File: rtl/disp_sequencer_if.sv
// Handshake bundle between the display sequencer and the swap/render engines.
// The sequencer is the master: it issues swap_start/start and receives swap_done/done.
interface disp_sequencer_if #(
   parameter int N = 4
);
   logic         swap_start;
   logic         swap_done;
   logic [N-1:0] start;
   logic [N-1:0] done;

   modport master (
      output swap_start,
      output start,
      input  swap_done,
      input  done
   );

   modport slave (
      input  swap_start,
      input  start,
      output swap_done,
      output done
   );
endinterface

// File: rtl/disp_sequencer.sv
// Frame sequencer: each frame begins with a buffer swap, then runs the enabled render
// stages in ascending order. Every stage has a cycle limit; an overrun is flagged in err.
module disp_sequencer #(
   parameter int N  = 4,
   parameter int TW = 16
) (
   input  logic             clkSYS,
   input  logic             n_reset,
   input  logic             run,
   input  logic [N-1:0]     enable,
   input  logic [TW-1:0]    timeout,
   input  logic             err_clr,
   disp_sequencer_if.master bus,
   output logic             busy,
   output logic [3:0]       stage,
   output logic [15:0]      frame_cnt,
   output logic             err,
   output logic [3:0]       err_stage
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_SWAP  = 2'd1,
      S_STAGE = 2'd2
   } state_t;

   localparam logic [N-1:0]  ONE_N  = N'(1'b1);
   localparam logic [TW-1:0] ONE_TW = TW'(1'b1);

   function automatic logic [N-1:0] lowest_bit(input logic [N-1:0] x);
      return x & (~x + ONE_N);
   endfunction

   function automatic logic [3:0] oh_index(input logic [N-1:0] oh);
      logic [3:0] idx;
      idx = 4'h0;
      for (int k = 0; k < N; k++) begin
         if (oh[k]) begin
            idx = 4'(k);
         end else begin
            idx = idx;
         end
      end
      return idx;
   endfunction

   state_t        state_r;
   logic [N-1:0]  mask_r;
   logic [N-1:0]  cur_oh_r;
   logic [N-1:0]  start_r;
   logic [TW-1:0] tmo_cnt_r;
   logic          swap_start_r;
   logic          busy_r;
   logic [3:0]    stage_r;
   logic [15:0]   frame_cnt_r;
   logic          err_r;
   logic [3:0]    err_stage_r;

   logic          done_cur_s;
   logic          tmo_evt_s;
   logic          advance_s;
   logic [N-1:0]  first_oh_s;
   logic [N-1:0]  next_oh_s;
   logic [N-1:0]  launch_oh_s;
   logic          launch_s;
   logic          frame_end_s;

   // Stage completion/timeout decode and the choice of the next stage or frame end.
   always_comb begin
      done_cur_s  = |(bus.done & cur_oh_r);
      first_oh_s  = lowest_bit(enable);
      next_oh_s   = lowest_bit(mask_r & ~(cur_oh_r | (cur_oh_r - ONE_N)));
      tmo_evt_s   = 1'b0;
      launch_oh_s = {N{1'b0}};
      launch_s    = 1'b0;
      frame_end_s = 1'b0;
      if ((state_r == S_STAGE) && (timeout != {TW{1'b0}}) &&
          (tmo_cnt_r == timeout) && !done_cur_s) begin
         tmo_evt_s = 1'b1;
      end else begin
         tmo_evt_s = 1'b0;
      end
      advance_s = (state_r == S_STAGE) && (done_cur_s || tmo_evt_s);
      if ((state_r == S_SWAP) && bus.swap_done) begin
         launch_oh_s = first_oh_s;
         launch_s    = |first_oh_s;
         frame_end_s = ~|first_oh_s;
      end else if (advance_s) begin
         launch_oh_s = next_oh_s;
         launch_s    = |next_oh_s;
         frame_end_s = ~|next_oh_s;
      end else begin
         launch_oh_s = {N{1'b0}};
         launch_s    = 1'b0;
         frame_end_s = 1'b0;
      end
   end

   // Sequencer state, timeout counter and all registered outputs.
   always_ff @(posedge clkSYS or negedge n_reset) begin
      if (!n_reset) begin
         state_r      <= S_IDLE;
         mask_r       <= {N{1'b0}};
         cur_oh_r     <= {N{1'b0}};
         start_r      <= {N{1'b0}};
         tmo_cnt_r    <= {TW{1'b0}};
         swap_start_r <= 1'b0;
         busy_r       <= 1'b0;
         stage_r      <= 4'hF;
         frame_cnt_r  <= 16'h0000;
         err_r        <= 1'b0;
         err_stage_r  <= 4'h0;
      end else begin
         swap_start_r <= 1'b0;
         start_r      <= {N{1'b0}};

         // A timeout beats a simultaneous clear so the event is never lost.
         if (tmo_evt_s) begin
            err_r       <= 1'b1;
            err_stage_r <= oh_index(cur_oh_r);
         end else if (err_clr) begin
            err_r       <= 1'b0;
            err_stage_r <= 4'h0;
         end else begin
            err_r       <= err_r;
            err_stage_r <= err_stage_r;
         end

         case (state_r)
            S_IDLE: begin
               if (run) begin
                  state_r      <= S_SWAP;
                  swap_start_r <= 1'b1;
                  busy_r       <= 1'b1;
               end
            end
            S_SWAP: begin
               if (bus.swap_done) begin
                  mask_r <= enable;
               end
            end
            S_STAGE: begin
               tmo_cnt_r <= tmo_cnt_r + ONE_TW;
            end
            default: begin
               state_r <= S_IDLE;
               busy_r  <= 1'b0;
               stage_r <= 4'hF;
            end
         endcase

         if (launch_s) begin
            state_r   <= S_STAGE;
            cur_oh_r  <= launch_oh_s;
            start_r   <= launch_oh_s;
            stage_r   <= oh_index(launch_oh_s);
            tmo_cnt_r <= {TW{1'b0}};
         end else if (frame_end_s) begin
            frame_cnt_r <= frame_cnt_r + 16'd1;
            cur_oh_r    <= {N{1'b0}};
            stage_r     <= 4'hF;
            if (run) begin
               state_r      <= S_SWAP;
               swap_start_r <= 1'b1;
            end else begin
               state_r <= S_IDLE;
               busy_r  <= 1'b0;
            end
         end
      end
   end

   assign bus.swap_start = swap_start_r;
   assign bus.start      = start_r;
   assign busy           = busy_r;
   assign stage          = stage_r;
   assign frame_cnt      = frame_cnt_r;
   assign err            = err_r;
   assign err_stage      = err_stage_r;

endmodule

// File: doc/disp_sequencer.md
DISP_SEQUENCER -- requirements
Module: disp_sequencer

Interface
REQ-001 Parameter N, default 4: number of render stages, legal range 1..15; stage 0 runs first in a frame.
REQ-002 Parameter TW, default 16: timeout counter width.
REQ-003 clkSYS  in  1  system clock; all logic on rising edge.
REQ-004 n_reset  in  1  asynchronous, active-low reset.
REQ-005 run  in  1  free-run enable; 1 = start frames back to back.
REQ-006 enable  in  N  per-stage enable mask; sampled only at swap completion.
REQ-007 timeout  in  TW  per-stage cycle limit; 0 = timeout disabled.
REQ-008 err_clr  in  1  clears err and err_stage.
REQ-009 swap_start  out  1  one-cycle pulse requesting a buffer swap.
REQ-010 swap_done  in  1  swap complete, level or pulse.
REQ-011 start  out  N  one-hot, one-cycle stage start pulses.
REQ-012 done  in  N  per-stage completion flags.
REQ-013 busy  out  1  high whenever the state is not IDLE.
REQ-014 stage  out  4  active stage index; 4'hF in IDLE and SWAP.
REQ-015 frame_cnt  out  16  count of completed frames.
REQ-016 err  out  1  sticky stage-timeout flag.
REQ-017 err_stage  out  4  index of the most recent timed-out stage.

Function
REQ-018 States SHALL be IDLE, SWAP and STAGE; STAGE carries the index i.
REQ-019 IDLE with run=1 SHALL enter SWAP on the next edge, with swap_start high for exactly the first SWAP cycle.
REQ-020 SWAP SHALL wait for swap_done; on swap_done it SHALL latch enable into mask_q and select the lowest set bit of mask_q.
REQ-021 If mask_q is nonzero, the next cycle SHALL be STAGE i with start[i]=1 for that single cycle (registered start: one cycle after swap_done).
REQ-022 If mask_q is zero, the frame SHALL complete immediately per REQ-025.
REQ-023 In STAGE i, only done[i] SHALL be honoured, including in the start-pulse cycle; done[j] for j≠i SHALL be ignored.
REQ-024 On done[i], control SHALL move to the next higher set bit of mask_q, with start pulsed in the following cycle; if no higher set bit exists, the frame completes.
REQ-025 Frame completion SHALL increment frame_cnt (wrapping 16'hFFFF->0), then:
- run=1: enter SWAP with a swap_start pulse;
- run=0: enter IDLE.
REQ-026 Deasserting run mid-frame SHALL NOT abort; the current frame finishes and then enters IDLE.
REQ-027 Changes to enable mid-frame SHALL have no effect until the next swap_done.
REQ-028 Stage timeout counter:
- clears on entry to each STAGE;
- increments every STAGE cycle.
REQ-029 Timeout event: timeout≠0, counter equals timeout, and done[i]=0. It SHALL set err=1 and err_stage=i, then advance exactly as if done[i] had been seen.
REQ-030 done[i] and a timeout in the same cycle SHALL count as done; err SHALL NOT be set.
REQ-031 A timeout while err=1 SHALL update err_stage; err stays 1.
REQ-032 err_clr SHALL clear err and err_stage to 0; a timeout in the same cycle SHALL take priority (err=1, err_stage updated).
REQ-033 SWAP SHALL have no timeout.
REQ-034 At most one start bit SHALL be high in any cycle, and swap_start and start SHALL never be high together.

Reset
REQ-035 While n_reset=0, and on release, the following SHALL all be 0:
- state=IDLE;
- swap_start, start, busy, frame_cnt, err, err_stage, mask_q, timeout counter.
- stage SHALL be 4'hF.
REQ-036 Reset asserted mid-frame SHALL abort immediately; no further start pulses until a new run sequence begins.

Verification
REQ-037 N=4, run=1, enable=4'b1111, each done 3 cycles after its start -> pulse order swap_start, start[0], start[1], start[2], start[3], swap_start; each start exactly 1 cycle after the prior done/swap_done; frame_cnt=1.
REQ-038 enable=4'b1010 -> only start[1] then start[3]; stage reads 1 then 3; enable=4'b0000 -> frame_cnt increments on each swap_done with no start pulses.
REQ-039 timeout=5, done[2] never asserted -> err=1 and err_stage=2 in stage-2 cycle 6, then start[3] next cycle; done[2] together with the limit cycle -> err stays 0.
REQ-040 run dropped during stage 1 -> stages 2 and 3 still run, frame_cnt increments, busy falls, no swap_start follows.
REQ-041 frame_cnt preset to 16'hFFFF by completing 65535 frames (or forced) -> next frame reads 0.
REQ-042 n_reset pulsed while in STAGE 2 -> all outputs at reset values in the same cycle; done[2] afterwards is ignored.
